// File: rtl/uart_frame_rx.sv
// Frame parser behind a UART receiver: collects SOF, LEN, payload, CHK frames,
// validates them, and replays good payloads on a valid/ready byte stream.
module uart_frame_rx #(
  parameter int          MAX_LEN      = 16,
  parameter int          TIMEOUT_CLKS = 52080,
  parameter logic [7:0]  SOF          = 8'hAA
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  input  logic       i_ready,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_last,
  output logic       o_err_len,
  output logic       o_err_chk,
  output logic       o_err_timeout,
  output logic       o_overrun,
  output logic [7:0] o_frame_count
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS);

  typedef enum logic [2:0] {IDLE, GET_LEN, GET_PAY, GET_CHK, STREAM} state_t;

  state_t          state, state_d;
  logic [7:0]      len, len_d;
  logic [7:0]      sum, sum_d;
  logic [IW-1:0]   wr_idx, wr_idx_d;
  logic [IW-1:0]   rd_idx, rd_idx_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [7:0]      count_d;
  logic            err_len_d, err_chk_d, err_timeout_d, overrun_d;
  logic            buf_we;
  logic [7:0]      mem [MAX_LEN];

  assign buf_we = (state == GET_PAY) && i_rx_dv;

  // Payload storage carries no reset; its contents only matter once a frame is complete.
  always_ff @(posedge clock) begin
    if (buf_we) begin
      mem[wr_idx[AW-1:0]] <= i_rx_byte;
    end
  end

  always_comb begin
    state_d       = state;
    len_d         = len;
    sum_d         = sum;
    wr_idx_d      = wr_idx;
    rd_idx_d      = rd_idx;
    tcnt_d        = tcnt;
    count_d       = o_frame_count;
    err_len_d     = 1'b0;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;
    overrun_d     = 1'b0;

    case (state)
      IDLE: begin
        if (i_rx_dv && (i_rx_byte == SOF)) begin
          state_d = GET_LEN;
          tcnt_d  = '0;
        end
      end

      GET_LEN, GET_PAY, GET_CHK: begin
        // A byte arriving on the terminal count is processed and beats the timeout.
        if (i_rx_dv) begin
          tcnt_d = '0;
          if (state == GET_LEN) begin
            len_d = i_rx_byte;
            sum_d = i_rx_byte;
            if ((i_rx_byte == 8'd0) || (i_rx_byte > 8'(MAX_LEN))) begin
              err_len_d = 1'b1;
              state_d   = IDLE;
            end else begin
              wr_idx_d = '0;
              state_d  = GET_PAY;
            end
          end else if (state == GET_PAY) begin
            sum_d    = sum + i_rx_byte;
            wr_idx_d = wr_idx + 1'b1;
            if (8'(wr_idx) == (len - 8'd1)) begin
              state_d = GET_CHK;
            end
          end else begin
            if (i_rx_byte == sum) begin
              rd_idx_d = '0;
              state_d  = STREAM;
            end else begin
              err_chk_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end else if (tcnt == TW'(TIMEOUT_CLKS - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end

      STREAM: begin
        overrun_d = i_rx_dv;
        if (i_ready) begin
          if (o_last) begin
            count_d = o_frame_count + 8'd1;
            state_d = IDLE;
          end else begin
            rd_idx_d = rd_idx + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so the first payload byte
  // appears in the cycle right after the checksum byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      len           <= '0;
      sum           <= '0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      tcnt          <= '0;
      o_byte_valid  <= 1'b0;
      o_byte        <= '0;
      o_last        <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_chk     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
      o_frame_count <= '0;
    end else begin
      state         <= state_d;
      len           <= len_d;
      sum           <= sum_d;
      wr_idx        <= wr_idx_d;
      rd_idx        <= rd_idx_d;
      tcnt          <= tcnt_d;
      o_byte_valid  <= (state_d == STREAM);
      o_byte        <= (state_d == STREAM) ? mem[rd_idx_d[AW-1:0]] : 8'd0;
      o_last        <= (state_d == STREAM) && (8'(rd_idx_d) == (len_d - 8'd1));
      o_err_len     <= err_len_d;
      o_err_chk     <= err_chk_d;
      o_err_timeout <= err_timeout_d;
      o_overrun     <= overrun_d;
      o_frame_count <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed frames plus randomized frame traffic,
// checked against a transaction-level scoreboard of expected payloads and error counts.
module tb_uart_frame_rx;

  localparam int         MAX_LEN      = 16;
  localparam int         TIMEOUT_CLKS = 24;
  localparam logic [7:0] SOF          = 8'hAA;

  logic       clock;
  logic       reset_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       ready;
  logic       byte_valid;
  logic [7:0] out_byte;
  logic       last;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;
  logic       overrun;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;
  int exp_len = 0, exp_chk = 0, exp_to = 0, exp_ovr = 0, exp_frames = 0;
  int act_len = 0, act_chk = 0, act_to = 0, act_ovr = 0;
  logic       ready_rand = 1'b0;
  logic [8:0] sb[$];
  logic       hold_prev = 1'b0;
  logic [9:0] hold_data = '0;
  logic       prev_len = 1'b0, prev_chk = 1'b0, prev_to = 1'b0, prev_ovr = 1'b0;

  uart_frame_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TIMEOUT_CLKS), .SOF(SOF)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .i_rx_dv(rx_dv),
    .i_rx_byte(rx_byte),
    .i_ready(ready),
    .o_byte_valid(byte_valid),
    .o_byte(out_byte),
    .o_last(last),
    .o_err_len(err_len),
    .o_err_chk(err_chk),
    .o_err_timeout(err_timeout),
    .o_overrun(overrun),
    .o_frame_count(frame_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  always @(posedge clock) begin
    if (ready_rand) begin
      #1;
      ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Consumer side: compares handshaken bytes with the scoreboard, checks stall
  // stability and that every error output is a single-cycle pulse.
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_prev = 1'b0;
      prev_len = 1'b0; prev_chk = 1'b0; prev_to = 1'b0; prev_ovr = 1'b0;
    end else begin
      if (hold_prev) checkOutput("stall_hold", 32'({byte_valid, last, out_byte}), 32'(hold_data));
      if (byte_valid && ready) begin
        if (sb.size() == 0) checkOutput("unexpected_byte", 32'({last, out_byte}), 32'h1ff);
        else checkOutput("payload", 32'({last, out_byte}), 32'(sb.pop_front()));
      end
      hold_prev = byte_valid && !ready;
      hold_data = {byte_valid, last, out_byte};
      if (err_len)     begin act_len++; checkOutput("len_pulse_width", 32'(prev_len), 0); end
      if (err_chk)     begin act_chk++; checkOutput("chk_pulse_width", 32'(prev_chk), 0); end
      if (err_timeout) begin act_to++;  checkOutput("to_pulse_width",  32'(prev_to), 0);  end
      if (overrun)     begin act_ovr++; checkOutput("ovr_pulse_width", 32'(prev_ovr), 0); end
      prev_len = err_len; prev_chk = err_chk; prev_to = err_timeout; prev_ovr = overrun;
    end
  end

  task automatic waitDrain(input bit inject);
    int n;
    n = 0;
    while ((byte_valid || sb.size() != 0) && n < 600) begin
      if (inject && byte_valid && $urandom_range(0, 7) == 0) begin
        applyStimulus(8'($urandom_range(0, 255)));
        exp_ovr++;
        tick();
        n += 2;
      end else begin
        tick();
        n++;
      end
    end
    checkOutput("drain_done", 32'(byte_valid), 0);
    checkOutput("frame_count", 32'(frame_count), 32'(exp_frames & 255));
  endtask

  // kind: 0 good, 1 bad checksum, 2 bad length, 3 silence mid-payload
  task automatic sendFrame(input int kind, input int len, input int gap, input bit inject);
    int sum;
    logic [7:0] b;
    logic [7:0] pay[$];
    if ($urandom_range(0, 3) == 0) begin
      b = 8'($urandom_range(0, 255));
      if (b == SOF) b = 8'h00;
      applyStimulus(b);
    end
    applyStimulus(SOF);
    idleTicks($urandom_range(0, gap));
    if (kind == 2) begin
      b = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
      applyStimulus(b);
      exp_len++;
      return;
    end
    applyStimulus(8'(len));
    sum = len;
    for (int i = 0; i < len; i++) begin
      if (kind == 3 && i == len / 2) begin
        idleTicks(TIMEOUT_CLKS + 1);
        exp_to++;
        return;
      end
      b = 8'($urandom_range(0, 255));
      pay.push_back(b);
      sum = (sum + b) & 255;
      idleTicks($urandom_range(0, gap));
      applyStimulus(b);
    end
    idleTicks($urandom_range(0, gap));
    if (kind == 1) begin
      b = 8'(sum) ^ 8'($urandom_range(1, 255));
      exp_chk++;
      applyStimulus(b);
      return;
    end
    for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), pay[i]});
    exp_frames++;
    applyStimulus(8'(sum));
    waitDrain(inject);
  endtask

  task automatic checkCounters(input string phase);
    idleTicks(3);
    checkOutput({phase, "_err_len"}, act_len, exp_len);
    checkOutput({phase, "_err_chk"}, act_chk, exp_chk);
    checkOutput({phase, "_err_to"}, act_to, exp_to);
    checkOutput({phase, "_overrun"}, act_ovr, exp_ovr);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] pat [4];
    int n;
    reset_n = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    ready   = 1'b1;
    #23;
    checkOutput("reset_valid", 32'(byte_valid), 0);
    checkOutput("reset_count", 32'(frame_count), 0);
    checkOutput("reset_errs", 32'({err_len, err_chk, err_timeout, overrun, last, out_byte}), 0);
    reset_n = 1'b1;
    tick();

    $display("[TB] good frame");
    sb.push_back({1'b0, 8'h11}); sb.push_back({1'b0, 8'h22}); sb.push_back({1'b1, 8'h33});
    exp_frames++;
    applyStimulus(SOF); applyStimulus(8'h03); applyStimulus(8'h11);
    applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h69);
    checkOutput("good_b0", 32'({byte_valid, last, out_byte}), 32'({2'b10, 8'h11}));
    tick();
    checkOutput("good_b1", 32'({byte_valid, last, out_byte}), 32'({2'b10, 8'h22}));
    checkOutput("good_count_hold", 32'(frame_count), 0);
    tick();
    checkOutput("good_b2", 32'({byte_valid, last, out_byte}), 32'({2'b11, 8'h33}));
    tick();
    checkOutput("good_end_valid", 32'(byte_valid), 0);
    checkOutput("good_count", 32'(frame_count), 1);

    $display("[TB] bad checksum");
    applyStimulus(SOF); applyStimulus(8'h02); applyStimulus(8'h01); applyStimulus(8'h02);
    applyStimulus(8'h00);
    exp_chk++;
    checkOutput("chk_pulse", 32'({err_chk, byte_valid}), 32'(2'b10));
    tick();
    checkOutput("chk_pulse_end", 32'({err_chk, byte_valid}), 0);
    checkOutput("chk_count", 32'(frame_count), 1);

    $display("[TB] length errors");
    applyStimulus(SOF); applyStimulus(8'h00);
    exp_len++;
    checkOutput("len0_pulse", 32'(err_len), 1);
    tick();
    checkOutput("len0_pulse_end", 32'(err_len), 0);
    applyStimulus(SOF); applyStimulus(8'h11);
    exp_len++;
    checkOutput("len17_pulse", 32'(err_len), 1);
    sb.push_back({1'b1, 8'h5A});
    exp_frames++;
    applyStimulus(SOF); applyStimulus(8'h01); applyStimulus(8'h5A); applyStimulus(8'h5B);
    checkOutput("len1_byte", 32'({byte_valid, last, out_byte}), 32'({2'b11, 8'h5A}));
    tick();
    checkOutput("len1_count", 32'(frame_count), 2);

    $display("[TB] backpressure and overrun");
    pat[0] = 8'd1; pat[1] = 8'd0; pat[2] = 8'd0; pat[3] = 8'd1;
    ready = 1'b0;
    applyStimulus(SOF); applyStimulus(8'h04);
    for (int i = 0; i < 4; i++) begin
      sb.push_back({(i == 3), 8'(8'hC0 + i)});
      applyStimulus(8'(8'hC0 + i));
    end
    exp_frames++;
    applyStimulus(8'(8'h04 + 8'hC0 + 8'hC1 + 8'hC2 + 8'hC3));
    n = 0;
    while (byte_valid && n < 40) begin
      ready = pat[n % 4][0];
      if (n == 2) begin
        applyStimulus(SOF);
        exp_ovr++;
      end else begin
        tick();
      end
      n++;
    end
    checkOutput("bp_drained", 32'({byte_valid, 24'(sb.size())}), 0);
    checkOutput("bp_count", 32'(frame_count), 3);
    ready = 1'b1;

    $display("[TB] timeout");
    applyStimulus(SOF); applyStimulus(8'h05); applyStimulus(8'h01);
    idleTicks(TIMEOUT_CLKS - 1);
    checkOutput("to_before", 32'(err_timeout), 0);
    tick();
    exp_to++;
    checkOutput("to_pulse", 32'(err_timeout), 1);
    tick();
    checkOutput("to_pulse_end", 32'(err_timeout), 0);
    applyStimulus(SOF); applyStimulus(8'h05); applyStimulus(8'h01);
    idleTicks(TIMEOUT_CLKS - 1);
    for (int i = 1; i <= 5; i++) sb.push_back({(i == 5), 8'(i)});
    exp_frames++;
    applyStimulus(8'h02);
    checkOutput("to_suppressed", 32'(err_timeout), 0);
    applyStimulus(8'h03); applyStimulus(8'h04); applyStimulus(8'h05);
    applyStimulus(8'h14);
    waitDrain(1'b0);
    checkCounters("directed");

    $display("[TB] random frames");
    ready_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int r, kind;
      r = $urandom_range(0, 99);
      kind = (r < 65) ? 0 : (r < 78) ? 1 : (r < 88) ? 2 : 3;
      sendFrame(kind, $urandom_range(1, MAX_LEN),
                ($urandom_range(0, 9) == 0) ? TIMEOUT_CLKS - 2 : 2, 1'b1);
    end
    checkCounters("random");
    ready_rand = 1'b0;
    #2;
    ready = 1'b1;

    $display("[TB] reset mid-frame and mid-stream");
    applyStimulus(SOF); applyStimulus(8'h03); applyStimulus(8'h11);
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    tick();
    ready = 1'b0;
    applyStimulus(SOF); applyStimulus(8'h03); applyStimulus(8'h01);
    applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h09);
    checkOutput("pre_reset_valid", 32'({byte_valid, out_byte}), 32'({1'b1, 8'h01}));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'({byte_valid, last, out_byte}), 0);
    checkOutput("async_reset_count", 32'(frame_count), 0);
    checkOutput("async_reset_errs", 32'({err_len, err_chk, err_timeout, overrun}), 0);
    exp_frames = 0;
    #3 reset_n = 1'b1;
    ready = 1'b1;
    tick();

    $display("[TB] frame count wrap");
    for (int i = 1; i <= 256; i++) begin
      b = 8'($urandom_range(0, 255));
      sb.push_back({1'b1, b});
      exp_frames++;
      applyStimulus(SOF); applyStimulus(8'h01); applyStimulus(b);
      applyStimulus(8'(b + 8'd1));
      tick();
      if (i == 255) checkOutput("count_255", 32'(frame_count), 255);
    end
    checkOutput("count_wrap", 32'(frame_count), 32'(exp_frames & 255));
    checkOutput("count_wrap_zero", 32'(frame_count), 0);
    checkCounters("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
